// File: rtl/ipe_bfly.sv
// Pipelined inverse radix-2 butterfly: a = (y0 + y1*W)/2, b = (y0 - y1*W)/2.
// Sign-magnitude fixed point throughout, saturating, with per-sample and sticky overflow.
module ipe_bfly #(
  parameter int WL    = 16,
  parameter int FWL   = 10,
  parameter int SCALE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] y0_r,
  input  logic [WL-1:0] y0_i,
  input  logic [WL-1:0] y1_r,
  input  logic [WL-1:0] y1_i,
  input  logic [WL-1:0] tw_r,
  input  logic [WL-1:0] tw_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] a_r,
  output logic [WL-1:0] a_i,
  output logic [WL-1:0] b_r,
  output logic [WL-1:0] b_i,
  output logic          ovf,
  output logic          ovf_sticky,
  input  logic          ovf_clr
);
  localparam int   STAGES = 3;
  localparam int   MW     = WL - 1;
  localparam int   PW     = 2 * WL - 2;
  localparam logic HALF   = (SCALE != 0);
  localparam logic [PW-1:0] MAXP = PW'({MW{1'b1}});
  localparam logic [WL:0]   MAXA = (WL + 1)'({MW{1'b1}});

  typedef logic [WL-1:0] sm_t;
  typedef struct packed { logic ovf; sm_t v; } smr_t;
  typedef struct packed { sm_t y0r, y0i, y1r, y1i, twr, twi; } s1_t;
  typedef struct packed { sm_t y0r, y0i, pr, pi; logic ovf; } s2_t;
  typedef struct packed { sm_t ar, ai, br, bi; logic ovf; } s3_t;

  // Zero magnitude always leaves a stage with a positive sign.
  function automatic sm_t nz(sm_t x);
    return (x[MW-1:0] == '0) ? '0 : x;
  endfunction

  function automatic smr_t sm_mul(sm_t x, sm_t y);
    logic [PW-1:0] p;
    smr_t r;
    p = (PW'(x[MW-1:0]) * PW'(y[MW-1:0])) >> FWL;
    r.ovf = (p > MAXP);
    r.v = {x[WL-1] ^ y[WL-1], r.ovf ? {MW{1'b1}} : p[MW-1:0]};
    r.v = nz(r.v);
    return r;
  endfunction

  function automatic smr_t sm_add(sm_t x, sm_t y, logic sub, logic half);
    logic [WL:0] mx, my, m;
    logic sx, sy, s;
    smr_t r;
    mx = (WL + 1)'(x[MW-1:0]);
    my = (WL + 1)'(y[MW-1:0]);
    sx = x[WL-1];
    sy = y[WL-1] ^ sub;
    if (sx == sy) begin
      m = mx + my; s = sx;
    end else if (mx >= my) begin
      m = mx - my; s = sx;
    end else begin
      m = my - mx; s = sy;
    end
    if (half) m = m >> 1;
    r.ovf = (m > MAXA);
    r.v = {s, r.ovf ? {MW{1'b1}} : m[MW-1:0]};
    r.v = nz(r.v);
    return r;
  endfunction

  logic [STAGES:1] vld_pipe;
  logic            en;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  s3_t             s3_d, s3_q;
  smr_t            m_rr, m_ii, m_ri, m_ir, p_r, p_i, o_ar, o_ai, o_br, o_bi;

  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  always_comb begin
    s1_d.y0r = nz(y0_r);
    s1_d.y0i = nz(y0_i);
    s1_d.y1r = nz(y1_r);
    s1_d.y1i = nz(y1_i);
    s1_d.twr = nz(tw_r);
    s1_d.twi = nz(tw_i);
  end

  // p = y1 * W
  always_comb begin
    m_rr = sm_mul(s1_q.y1r, s1_q.twr);
    m_ii = sm_mul(s1_q.y1i, s1_q.twi);
    m_ri = sm_mul(s1_q.y1r, s1_q.twi);
    m_ir = sm_mul(s1_q.y1i, s1_q.twr);
    p_r  = sm_add(m_rr.v, m_ii.v, 1'b1, 1'b0);
    p_i  = sm_add(m_ri.v, m_ir.v, 1'b0, 1'b0);
    s2_d.y0r = s1_q.y0r;
    s2_d.y0i = s1_q.y0i;
    s2_d.pr  = p_r.v;
    s2_d.pi  = p_i.v;
    s2_d.ovf = m_rr.ovf | m_ii.ovf | m_ri.ovf | m_ir.ovf | p_r.ovf | p_i.ovf;
  end

  always_comb begin
    o_ar = sm_add(s2_q.y0r, s2_q.pr, 1'b0, HALF);
    o_ai = sm_add(s2_q.y0i, s2_q.pi, 1'b0, HALF);
    o_br = sm_add(s2_q.y0r, s2_q.pr, 1'b1, HALF);
    o_bi = sm_add(s2_q.y0i, s2_q.pi, 1'b1, HALF);
    s3_d.ar  = o_ar.v;
    s3_d.ai  = o_ai.v;
    s3_d.br  = o_br.v;
    s3_d.bi  = o_bi.v;
    s3_d.ovf = s2_q.ovf | o_ar.ovf | o_ai.ovf | o_br.ovf | o_bi.ovf;
  end

  // Single global enable: bubbles keep their slot while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && s3_q.ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)                            ovf_sticky <= 1'b0;
  end

  assign a_r = s3_q.ar;
  assign a_i = s3_q.ai;
  assign b_r = s3_q.br;
  assign b_i = s3_q.bi;
  assign ovf = s3_q.ovf;

endmodule

// File: tb/tb_ipe_bfly.sv
// Bench for ipe_bfly: SCALE=1 and SCALE=0 instances share stimulus; an integer-arithmetic
// model plus a scoreboard queue checks every output cycle, with literal vectors pinning the model.
module tb_ipe_bfly;
  logic        clk, rst_n, in_valid, out_ready, ovf_clr;
  logic [15:0] y0_r, y0_i, y1_r, y1_i, tw_r, tw_i;
  logic        in_ready1, out_valid1, ovf1, st1;
  logic        in_ready0, out_valid0, ovf0, st0;
  logic [15:0] a_r1, a_i1, b_r1, b_i1, a_r0, a_i0, b_r0, b_i0;

  int nchk = 0;
  int nerr = 0;
  int ntx  = 0;

  ipe_bfly #(.WL(16), .FWL(10), .SCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i), .tw_r(tw_r), .tw_i(tw_i),
    .out_valid(out_valid1), .out_ready(out_ready),
    .a_r(a_r1), .a_i(a_i1), .b_r(b_r1), .b_i(b_i1),
    .ovf(ovf1), .ovf_sticky(st1), .ovf_clr(ovf_clr));

  ipe_bfly #(.WL(16), .FWL(10), .SCALE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i), .tw_r(tw_r), .tw_i(tw_i),
    .out_valid(out_valid0), .out_ready(out_ready),
    .a_r(a_r0), .a_i(a_i0), .b_r(b_r0), .b_i(b_i0),
    .ovf(ovf0), .ovf_sticky(st0), .ovf_clr(ovf_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y0r, y0i, y1r, y1i, twr, twi;
    bit rt;
    int ar, ai, br, bi;
  } item_t;
  typedef struct { int ar, ai, br, bi; bit ovf; } res_t;

  item_t q[$];
  bit rt_en;
  int rt_ar, rt_ai, rt_br, rt_bi;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_tol(string nm, int got, int exp, int tol);
    int d;
    nchk++;
    d = got - exp;
    if (d > tol || d < -tol) begin
      nerr++;
      $display("FAIL %s: got=%0d expected=%0d +/-%0d", nm, got, exp, tol);
    end
  endtask

  // Reference arithmetic on signed integers, saturating at +/-32767.
  function automatic int sm2i(logic [15:0] x);
    return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
  endfunction

  function automatic logic [15:0] i2sm(int v);
    if (v < 0) return {1'b1, 15'(-v)};
    return {1'b0, 15'(v)};
  endfunction

  function automatic int sat(int v, output bit o);
    o = (v > 32767) || (v < -32767);
    if (v > 32767) return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  function automatic int mulm(int x, int y, output bit o);
    return sat((x * y) / 1024, o);
  endfunction

  function automatic int addm(int x, int y, bit half, output bit o);
    int s;
    s = x + y;
    if (half) s = s / 2;
    return sat(s, o);
  endfunction

  function automatic res_t model(item_t it, bit half);
    bit [9:0] o;
    int mrr, mii, mri, mir, pr, pi, y0r, y0i;
    res_t r;
    mrr = mulm(sm2i(it.y1r), sm2i(it.twr), o[0]);
    mii = mulm(sm2i(it.y1i), sm2i(it.twi), o[1]);
    mri = mulm(sm2i(it.y1r), sm2i(it.twi), o[2]);
    mir = mulm(sm2i(it.y1i), sm2i(it.twr), o[3]);
    pr  = addm(mrr, -mii, 1'b0, o[4]);
    pi  = addm(mri, mir, 1'b0, o[5]);
    y0r = sm2i(it.y0r);
    y0i = sm2i(it.y0i);
    r.ar = addm(y0r, pr, half, o[6]);
    r.ai = addm(y0i, pi, half, o[7]);
    r.br = addm(y0r, -pr, half, o[8]);
    r.bi = addm(y0i, -pi, half, o[9]);
    r.ovf = |o;
    return r;
  endfunction

  // Scoreboard / compare process, sampled mid-cycle.
  bit          st1_m, st0_m, stall_p;
  logic [15:0] h_ar, h_ai, h_br, h_bi;
  item_t       cur, nw;
  res_t        e1, e0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      st1_m = 1'b0; st0_m = 1'b0; stall_p = 1'b0;
    end else begin
      chk("in_ready1", in_ready1, !(out_valid1 && !out_ready));
      chk("in_ready0", in_ready0, !(out_valid0 && !out_ready));
      chk("sticky1", st1, st1_m);
      chk("sticky0", st0, st0_m);
      if (stall_p) begin
        chk("hold_valid", out_valid1, 1);
        chk("hold_a_r", a_r1, h_ar); chk("hold_a_i", a_i1, h_ai);
        chk("hold_b_r", b_r1, h_br); chk("hold_b_i", b_i1, h_bi);
      end
      stall_p = out_valid1 && !out_ready;
      h_ar = a_r1; h_ai = a_i1; h_br = b_r1; h_bi = b_i1;
      e1.ovf = 1'b0; e0.ovf = 1'b0;
      if (out_valid1 || out_valid0) begin
        if (q.size() == 0) chk("spurious_out", {out_valid1, out_valid0}, 0);
        else begin
          cur = q[0];
          e1 = model(cur, 1'b1);
          e0 = model(cur, 1'b0);
          chk("out_valid1", out_valid1, 1); chk("out_valid0", out_valid0, 1);
          chk("s1_a_r", a_r1, i2sm(e1.ar)); chk("s1_a_i", a_i1, i2sm(e1.ai));
          chk("s1_b_r", b_r1, i2sm(e1.br)); chk("s1_b_i", b_i1, i2sm(e1.bi));
          chk("s1_ovf", ovf1, e1.ovf);
          chk("s0_a_r", a_r0, i2sm(e0.ar)); chk("s0_a_i", a_i0, i2sm(e0.ai));
          chk("s0_b_r", b_r0, i2sm(e0.br)); chk("s0_b_i", b_i0, i2sm(e0.bi));
          chk("s0_ovf", ovf0, e0.ovf);
          if (cur.rt) begin
            chk_tol("rt_a_r", sm2i(a_r1), cur.ar, 2); chk_tol("rt_a_i", sm2i(a_i1), cur.ai, 2);
            chk_tol("rt_b_r", sm2i(b_r1), cur.br, 2); chk_tol("rt_b_i", sm2i(b_i1), cur.bi, 2);
          end
        end
      end
      if (out_valid1 && out_ready && e1.ovf) st1_m = 1'b1;
      else if (ovf_clr) st1_m = 1'b0;
      if (out_valid0 && out_ready && e0.ovf) st0_m = 1'b1;
      else if (ovf_clr) st0_m = 1'b0;
      if (out_valid1 && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        ntx++;
      end
      if (in_valid && in_ready1) begin
        nw.y0r = y0_r; nw.y0i = y0_i; nw.y1r = y1_r; nw.y1i = y1_i;
        nw.twr = tw_r; nw.twi = tw_i;
        nw.rt = rt_en; nw.ar = rt_ar; nw.ai = rt_ai; nw.br = rt_br; nw.bi = rt_bi;
        q.push_back(nw);
      end
    end
  end

  // Present one sample and hold it until accepted; leaves in_valid high.
  task automatic send(input logic [15:0] v0r, v0i, v1r, v1i, wr, wi);
    bit acc;
    acc = 1'b0;
    y0_r = v0r; y0_i = v0i; y1_r = v1r; y1_i = v1i; tw_r = wr; tw_i = wi;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready1;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", in_ready1, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, tx0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    y0_r = '0; y0_i = '0; y1_r = '0; y1_i = '0; tw_r = '0; tw_i = '0;
    rt_en = 1'b0; rt_ar = 0; rt_ai = 0; rt_br = 0; rt_bi = 0;
    #12;
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_in_ready", in_ready1, 1);
    chk("rst_a_r", a_r1, 0);
    chk("rst_sticky", st0, 0);
    chk("rst_ovf", ovf0, 0);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;

    // identity twiddle
    send(16'h0800, 16'h0000, 16'h0400, 16'h0000, 16'h0400, 16'h0000);
    in_valid = 1'b0;
    wait_out(lat);
    chk("id_lat", lat, 3);
    chk("id_a_r", a_r1, 16'h0600); chk("id_a_i", a_i1, 16'h0000);
    chk("id_b_r", b_r1, 16'h0200); chk("id_ovf", ovf1, 0);
    chk("id_a_r_s0", a_r0, 16'h0C00); chk("id_b_r_s0", b_r0, 16'h0400);
    @(posedge clk); #1;

    // W = -j, exercises negative-zero products
    send(16'h0800, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h8400);
    in_valid = 1'b0;
    wait_out(lat);
    chk("mj_lat", lat, 3);
    chk("mj_a_r", a_r1, 16'h0600); chk("mj_a_i", a_i1, 16'h0000);
    chk("mj_b_r", b_r1, 16'h0200); chk("mj_b_i", b_i1, 16'h0000);
    @(posedge clk); #1;

    // saturation
    send(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h0400, 16'h0000);
    in_valid = 1'b0;
    wait_out(lat);
    chk("sat_lat", lat, 3);
    chk("sat_a_r_s0", a_r0, 16'h7FFF); chk("sat_ovf_s0", ovf0, 1);
    chk("sat_a_r_s1", a_r1, 16'h7FFF); chk("sat_ovf_s1", ovf1, 0);
    chk("sat_b_r_s1", b_r1, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk("sat_sticky_s0", st0, 1); chk("sat_sticky_s1", st1, 0);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("clr_sticky_s0", st0, 0);
    @(posedge clk); #1;

    // backpressure with out_ready toggling 1010...
    tx0 = ntx;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send({k[0], 15'(k * 300)}, {k[1], 15'(1000 + k * 77)},
               {k[2], 15'(k * 512)}, {~k[0], 15'(2048 - k * 100)},
               {k[1], 15'(724)}, {k[2], 15'(724 - k * 50)});
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 24; c++) begin
          out_ready = (c % 2 == 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("bp_count", ntx - tx0, 8);

    // async reset mid-stream
    send(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h0400, 16'h0000);
    send(16'h1000, 16'h8200, 16'h0300, 16'h0400, 16'h0400, 16'h8000);
    send(16'h8100, 16'h0050, 16'h8300, 16'h0123, 16'h0000, 16'h0400);
    send(16'h0400, 16'h0400, 16'h0100, 16'h8100, 16'h02D4, 16'h82D4);
    y0_r = 16'h0123;
    @(posedge clk); #1;
    chk("pre_rst_sticky_s0", st0, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid1", out_valid1, 0); chk("arst_out_valid0", out_valid0, 0);
    chk("arst_a_r", a_r1, 0); chk("arst_b_r_s0", b_r0, 0);
    chk("arst_ovf_s0", ovf0, 0); chk("arst_sticky_s0", st0, 0);
    chk("arst_in_ready", in_ready1, 1);
    in_valid = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0800, 16'h0000, 16'h0400, 16'h0000, 16'h0400, 16'h0000);
    in_valid = 1'b0;
    wait_out(lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_a_r", a_r1, 16'h0600);
    @(posedge clk); #1;

    // round trip through a forward-butterfly model, W from the exact unit twiddles
    for (int n = 0; n < 12; n++) begin
      int ar, ai, br, bi, wr, wi, dr, di, y1r, y1i, ws;
      bit o;
      ar = int'($urandom_range(16382)) - 8191;
      ai = int'($urandom_range(16382)) - 8191;
      br = int'($urandom_range(16382)) - 8191;
      bi = int'($urandom_range(16382)) - 8191;
      ws = int'($urandom_range(3));
      wr = (ws == 0) ? 1024 : (ws == 1) ? -1024 : 0;
      wi = (ws == 2) ? 1024 : (ws == 3) ? -1024 : 0;
      dr = ar - br;
      di = ai - bi;
      y1r = addm(mulm(dr, wr, o), mulm(di, wi, o), 1'b0, o);
      y1i = addm(mulm(di, wr, o), -mulm(dr, wi, o), 1'b0, o);
      rt_en = 1'b1; rt_ar = ar; rt_ai = ai; rt_br = br; rt_bi = bi;
      send(i2sm(ar + br), i2sm(ai + bi), i2sm(y1r), i2sm(y1i), i2sm(wr), i2sm(wi));
    end
    in_valid = 1'b0;
    rt_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
